scrambler_seq: RTL and testbench

Sequencing and lock controller for the 58-bit scrambler in the PCS receive path. It watches the incoming 64-bit block stream, seeds the scrambler from blocks flagged as sync blocks, and steps it once per data block. It checks each later sync-block seed against the scrambler's live state and declares lock or loss of lock. It sits between the block aligner and the scrambler, driving the scrambler's `scrambler_next`, `scrambler_load` and `scrambler_load_data` inputs.

---
 rtl/scrambler_seq.sv | 145 ++++++++++++++
 tb/tb_scrambler_seq.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/scrambler_seq.sv
// scrambler_seq: seeds and steps the PCS receive scrambler from the block stream and tracks sync-block lock.
// Define SCR_SEQ_TIMEOUT_EN to build the LOCKED-state timeout watchdog (tmo_cnt).
module scrambler_seq #(
   parameter int LOCK_CNT = 4,
   parameter int MISS_CNT = 3,
   parameter int TIMEOUT  = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        blk_valid,
   input  logic        blk_is_sync,
   input  logic [57:0] blk_seed,
   input  logic [57:0] scr_state,
   output logic        scrambler_next,
   output logic        scrambler_load,
   output logic [57:0] scrambler_load_data,
   output logic        locked,
   output logic [1:0]  state,
   output logic        sync_err,
   output logic [15:0] err_count
);

   localparam logic [1:0] HUNT   = 2'd0;
   localparam logic [1:0] CHECK  = 2'd1;
   localparam logic [1:0] LOCKED = 2'd2;

   localparam int MC_W = $clog2(LOCK_CNT + 1);
   localparam int MS_W = $clog2(MISS_CNT + 1);
   localparam logic [MC_W-1:0] LOCK_V = MC_W'(LOCK_CNT);
   localparam logic [MS_W-1:0] MISS_V = MS_W'(MISS_CNT);

   logic [MC_W-1:0] match_cnt, match_cnt_nxt;
   logic [MS_W-1:0] miss_cnt, miss_cnt_nxt;
   logic [1:0]      state_nxt;
   logic            sync, data, match, fail, tmo_hit;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign sync  = blk_valid & blk_is_sync & enable & ~reset;
   assign data  = blk_valid & ~blk_is_sync & enable & ~reset;
   assign match = (blk_seed == scr_state);

   // Stage p0: zero-latency scrambler controls, same cycle as the block
   assign scrambler_load_data = blk_seed;
   assign scrambler_load = sync & ((state == HUNT) | ((state == CHECK) & ~match));
   assign scrambler_next = ((state == CHECK) | (state == LOCKED)) &
                           (data | (sync & ((state == LOCKED) | match)));

`ifdef SCR_SEQ_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_V = TMO_W'(TIMEOUT);

   logic [TMO_W-1:0] tmo_cnt, tmo_cnt_nxt, tmo_inc;

   assign tmo_inc = tmo_cnt + TMO_W'(1);
   assign tmo_hit = (state == LOCKED) & data & (tmo_inc == TMO_V);

   always_comb begin
      tmo_cnt_nxt = tmo_cnt;
      if (!enable || (state != LOCKED) || tmo_hit || (sync && match))
         tmo_cnt_nxt = '0;
      else if (data)
         tmo_cnt_nxt = tmo_inc;
   end

   always_ff @(posedge clk) begin
      if (reset)
         tmo_cnt <= '0;
      else
         tmo_cnt <= tmo_cnt_nxt;
   end
`else
   assign tmo_hit = 1'b0;
`endif

   always_comb begin
      state_nxt     = state;
      match_cnt_nxt = match_cnt;
      miss_cnt_nxt  = miss_cnt;
      fail          = 1'b0;
      case (state)
         HUNT: begin
            if (sync) begin
               match_cnt_nxt = '0;
               state_nxt     = CHECK;
            end
         end
         CHECK: begin
            if (sync) begin
               if (match) begin
                  match_cnt_nxt = match_cnt + MC_W'(1);
                  if (match_cnt_nxt == LOCK_V) begin
                     state_nxt    = LOCKED;
                     miss_cnt_nxt = '0;
                  end
               end else begin
                  match_cnt_nxt = '0;
                  fail          = 1'b1;
               end
            end
         end
         LOCKED: begin
            if (sync && match)
               miss_cnt_nxt = '0;
            // A seed mismatch and a watchdog expiry are the same kind of failure here
            if ((sync && !match) || tmo_hit) begin
               fail         = 1'b1;
               miss_cnt_nxt = miss_cnt + MS_W'(1);
               if (miss_cnt_nxt == MISS_V)
                  state_nxt = HUNT;
            end
         end
         default: state_nxt = HUNT;
      endcase
      if (!enable) begin
         state_nxt     = HUNT;
         match_cnt_nxt = '0;
         miss_cnt_nxt  = '0;
      end
   end

   // Stage p1: registered state, lock flag and error reporting
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= HUNT;
         locked    <= 1'b0;
         sync_err  <= 1'b0;
         err_count <= '0;
         match_cnt <= '0;
         miss_cnt  <= '0;
      end else begin
         state     <= state_nxt;
         locked    <= (state_nxt == LOCKED);
         sync_err  <= fail;
         if (fail)
            err_count <= sat_inc16(err_count);
         match_cnt <= match_cnt_nxt;
         miss_cnt  <= miss_cnt_nxt;
      end
   end

endmodule

// File: tb/tb_scrambler_seq.sv
// Bench for scrambler_seq: directed vector table, hand sequences and random traffic against a behavioural model.
module tb_scrambler_seq;
   localparam int LOCK_CNT = 4;
   localparam int MISS_CNT = 3;
   localparam int TIMEOUT  = 1024;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        blk_valid = 1'b0;
   logic        blk_is_sync = 1'b0;
   logic [57:0] blk_seed = '0;
   logic [57:0] scr_state;
   logic        scrambler_next, scrambler_load;
   logic [57:0] scrambler_load_data;
   logic        locked;
   logic [1:0]  state;
   logic        sync_err;
   logic [15:0] err_count;

   int n_cmp = 0;
   int n_bad = 0;
   int cnt_next = 0, cnt_load = 0, cnt_err = 0;

   // behavioural model of the controller's visible state
   int m_state = 0, m_match = 0, m_miss = 0, m_tmo = 0, m_err = 0;
   bit m_locked = 1'b0, m_serr = 1'b0;

   // scrambler stand-in: reacts to the DUT's controls like the real one
   logic [57:0] scr = 58'h2A5_5A5A_C3C3_1234;

   typedef struct {
      bit r, en, v, s, mt;
      bit nx, ld;
      logic [1:0] st;
   } vec_t;
   vec_t tbl[22];

   scrambler_seq #(.LOCK_CNT(LOCK_CNT), .MISS_CNT(MISS_CNT), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .enable(enable), .blk_valid(blk_valid),
      .blk_is_sync(blk_is_sync), .blk_seed(blk_seed), .scr_state(scr_state),
      .scrambler_next(scrambler_next), .scrambler_load(scrambler_load),
      .scrambler_load_data(scrambler_load_data), .locked(locked), .state(state),
      .sync_err(sync_err), .err_count(err_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (scrambler_load === 1'b1)
         scr <= scrambler_load_data;
      else if (scrambler_next === 1'b1)
         scr <= {scr[56:0], scr[57] ^ scr[38]};
   end
   assign scr_state = scr;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic cyc(input bit r, input bit en, input bit v, input bit s, input bit want_m,
                      input bit use_sd = 1'b0, input logic [57:0] sd = '0);
      bit e_next, e_load, fl, mt;
      int ns, nm, nms, nt;
      @(posedge clk);
      #1;
      reset = r; enable = en; blk_valid = v; blk_is_sync = s;
      if (use_sd)      blk_seed = sd;
      else if (want_m) blk_seed = scr;
      else             blk_seed = scr ^ ({26'd0, 32'($urandom)} | 58'd1);
      mt = (blk_seed == scr);
      e_next = 1'b0; e_load = 1'b0; fl = 1'b0;
      ns = m_state; nm = m_match; nms = m_miss; nt = m_tmo;
      if (r || !en) begin
         ns = 0; nm = 0; nms = 0; nt = 0;
      end else begin
         case (m_state)
            0: if (v && s) begin e_load = 1'b1; nm = 0; ns = 1; end
            1: begin
               if (v && !s) e_next = 1'b1;
               else if (v && s && mt) begin
                  e_next = 1'b1; nm = m_match + 1;
                  if (nm == LOCK_CNT) begin ns = 2; nms = 0; nt = 0; end
               end else if (v && s) begin
                  e_load = 1'b1; nm = 0; fl = 1'b1;
               end
            end
            2: begin
               if (v && !s) begin
                  e_next = 1'b1;
`ifdef SCR_SEQ_TIMEOUT_EN
                  nt = m_tmo + 1;
                  if (nt == TIMEOUT) begin fl = 1'b1; nt = 0; end
`endif
               end else if (v && s && mt) begin
                  e_next = 1'b1; nms = 0; nt = 0;
               end else if (v && s) begin
                  e_next = 1'b1; fl = 1'b1;
               end
               if (fl) begin
                  nms = m_miss + 1;
                  if (nms == MISS_CNT) ns = 0;
               end
            end
            default: ns = 0;
         endcase
      end
      #3;
      chk("next", 64'(scrambler_next), 64'(e_next));
      chk("load", 64'(scrambler_load), 64'(e_load));
      chk("load_data", 64'(scrambler_load_data), 64'(blk_seed));
      chk("state", 64'(state), 64'(m_state));
      chk("locked", 64'(locked), 64'(m_locked));
      chk("sync_err", 64'(sync_err), 64'(m_serr));
      chk("err_count", 64'(err_count), 64'(m_err));
      if (scrambler_next === 1'b1) cnt_next++;
      if (scrambler_load === 1'b1) cnt_load++;
      if (sync_err === 1'b1)       cnt_err++;
      if (r) begin
         m_state = 0; m_match = 0; m_miss = 0; m_tmo = 0; m_err = 0;
         m_locked = 1'b0; m_serr = 1'b0;
      end else begin
         m_state = ns; m_match = nm; m_miss = nms; m_tmo = nt;
         m_serr = fl;
         if (fl && m_err < 65535) m_err++;
         m_locked = (ns == 2);
      end
   endtask

   initial begin
      //          r     en    v     s     mt    nx    ld    st
      tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
      tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
      tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
      tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0};
      tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1};
      tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1};
      tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1};
      tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1};
      tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1};
      tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1};
      tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1};
      tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1};
      tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2};
      tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2};
      tbl[14] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2};
      tbl[15] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2};
      tbl[16] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2};
      tbl[17] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2};
      tbl[18] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
      tbl[19] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0};
      tbl[20] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1};
      tbl[21] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};

      repeat (2) @(posedge clk);

      for (int i = 0; i < 22; i++) begin
         cyc(tbl[i].r, tbl[i].en, tbl[i].v, tbl[i].s, tbl[i].mt);
         chk($sformatf("tbl%0d_next", i), 64'(scrambler_next), 64'(tbl[i].nx));
         chk($sformatf("tbl%0d_load", i), 64'(scrambler_load), 64'(tbl[i].ld));
         chk($sformatf("tbl%0d_state", i), 64'(state), 64'(tbl[i].st));
      end

      // seeding with a known value, then four spaced matches to lock
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 58'h0123456789ABCDE);
      chk("seed_load", 64'(scrambler_load), 64'd1);
      chk("seed_data", 64'(scrambler_load_data), 64'h0123456789ABCDE);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("seed_state", 64'(state), 64'd1);
      cnt_next = 0; cnt_err = 0;
      for (int k = 0; k < 4; k++) begin
         repeat (10) cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
         cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      end
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("lock_locked", 64'(locked), 64'd1);
      chk("lock_next_pulses", 64'(cnt_next), 64'd44);
      chk("lock_err_pulses", 64'(cnt_err), 64'd0);

      // LOCKED misses with one match in between, then three in a row
      cnt_load = 0; cnt_err = 0;
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("miss_still_locked", 64'(state), 64'd2);
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("miss_state", 64'(state), 64'd0);
      chk("miss_locked", 64'(locked), 64'd0);
      chk("miss_err_pulses", 64'(cnt_err), 64'd5);
      chk("miss_no_load", 64'(cnt_load), 64'd0);

      // long run of data blocks in LOCKED
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      repeat (LOCK_CNT) cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      cnt_err = 0;
      repeat (TIMEOUT) cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef SCR_SEQ_TIMEOUT_EN
      chk("tmo_pulses", 64'(cnt_err), 64'd1);
`else
      chk("tmo_pulses", 64'(cnt_err), 64'd0);
`endif
      repeat (2) cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef SCR_SEQ_TIMEOUT_EN
      chk("tmo_miss_state", 64'(state), 64'd0);
`else
      chk("tmo_miss_state", 64'(state), 64'd2);
`endif

      // CHECK mismatch, then enable dropped with a block present
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("chk_mis_load", 64'(scrambler_load), 64'd1);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("chk_mis_pulse", 64'(sync_err), 64'd1);
      chk("chk_mis_errcnt", 64'(err_count), 64'd1);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("en_low_next", 64'(scrambler_next), 64'd0);
      chk("en_low_load", 64'(scrambler_load), 64'd0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("en_low_state", 64'(state), 64'd0);
      chk("en_low_errcnt", 64'(err_count), 64'd1);

      // random traffic
      repeat (3000) begin
         cyc(($urandom % 200) == 0, ($urandom % 20) != 0, ($urandom % 5) != 0,
             ($urandom % 3) == 0, ($urandom % 4) != 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
